modulo_matriz_buffer: RTL and testbench
=======================================

Name: modulo_matriz_buffer

Overview:
Parametrised, double-buffered frame register for the LED dot-matrix display. It succeeds the fixed 35-bit flip-flop register bank.
- Software-side logic writes one row at a time into a back buffer.
- A swap request copies the back buffer into the active buffer, but only at a frame boundary, so the display never tears.
- A built-in row scanner drives one-hot row select and column data to the matrix pins.

Parameters:
ROWS, 7, number of matrix rows (>=2)
COLS, 5, number of matrix columns (>=1)
SCAN_DIV, 1000, clk cycles each row is held on the pins (>=1)

Ports:
clk  input  1  system clock; all state changes on rising edge
clr  input  1  asynchronous active-low reset; clears all state immediately when 0
wr_en  input  1  write strobe for back buffer
wr_row  input  $clog2(ROWS)  target row index for write
wr_data  input  COLS  row data; bit c = column c, 1 = LED on
swap_req  input  1  single-cycle request to publish back buffer
swap_ack  output  1  single-cycle pulse in the cycle after the swap took effect
frame_out  output  ROWS*COLS  flat copy of active buffer; bit r*COLS+c = row r, column c
row_sel  output  ROWS  one-hot active row drive
col_out  output  COLS  active-buffer data for the row in row_sel
frame_start  output  1  single-cycle pulse when row 0 becomes active

Behaviour:
- Reset (clr=0, async):
  - back buffer, active buffer, frame_out and col_out all 0
  - row_sel = 1 (row 0); div counter = 0; row counter = 0
  - swap pending = 0; swap_ack = 0; frame_start = 0
  - Reset mid-frame or mid-swap discards pending swap and all stored data.
- Write:
  - When wr_en=1 and wr_row<ROWS, back[wr_row] <= wr_data on the next edge.
  - wr_row>=ROWS: write ignored, no state change.
  - Writes never touch the active buffer.
- Scan:
  - Div counter counts 0..SCAN_DIV-1.
  - When div==SCAN_DIV-1, div <= 0 and row <= (row==ROWS-1) ? 0 : row+1.
  - row_sel and col_out are registered: updated on the same edge as the row counter, so they are always mutually consistent. col_out = active[new row].
  - SCAN_DIV=1: row advances every cycle.
- Frame boundary: div==SCAN_DIV-1 and row==ROWS-1.
- frame_start:
  - Pulses 1 for one cycle in the cycle after the boundary edge, i.e. while row_sel=1 is first driven.
  - Not asserted out of reset.
- Swap:
  - swap_req=1 sets pending.
  - Additional requests while pending are merged; one swap results.
  - At a boundary edge with (pending | swap_req): active <= back, pending <= 0, swap_ack <= 1 for exactly one cycle.
  - col_out on that same edge takes row 0 of the new data.
- Simultaneous write and swap on a boundary edge: active receives the back value from before the write; the write lands in back only. It is visible at the next swap.
- swap_req arriving after the boundary edge waits a full frame (ROWS*SCAN_DIV cycles worst case).
- frame_out = active buffer, flattened, registered (no extra latency beyond the active register).
- Latency, swap_req to swap_ack: at least 1 cycle, at most ROWS*SCAN_DIV cycles.

Decomposition:
- Shared package modulo_matriz_pkg holds:
  - index-width helper function, ROW_W = $clog2(ROWS)
  - flat-index helper idx(r,c) = r*COLS + c
  - default geometry constants (7, 5)
- Natural sub-module: modulo_varredura_linhas, holding the div counter, row counter, row_sel one-hot and boundary/frame_start generation. Its parameters are ROWS and SCAN_DIV; it outputs row index, row_sel, boundary and frame_start.
- Top level holds the two buffers, swap-pending logic and column mux.

Test Plan:
All scenarios use ROWS=7, COLS=5, SCAN_DIV=4.
- Reset values: hold clr=0, then release → all outputs 0 except row_sel=7'b0000001. First row_sel change to 7'b0000010 comes 4 cycles after release.
- Write without swap: write back[2]=5'b10101 → frame_out and col_out stay all-zero for 3 full frames (84 cycles); swap_ack never asserts.
- Swap at boundary: write rows 0..6 = 5'h01..5'h07, pulse swap_req mid-frame at row 3 →
  - swap_ack pulses once, exactly at the next boundary
  - frame_out[4:0]=5'h01, frame_out[34:30]=5'h07
  - col_out follows 5'h01..5'h07 as row_sel walks through its rows
- Merged and late requests: pulse swap_req 3 times in one frame → one swap_ack. Pulse swap_req 1 cycle after a boundary → swap_ack after exactly 28 cycles.
- Simultaneous write and swap: on the boundary cycle, assert swap_req plus wr_en with row 0 = 5'h1F (old back row 0 = 5'h01) → active row 0 = 5'h01; a second swap makes it 5'h1F.
- Mid-operation reset and invalid row:
  - wr_row=7 with wr_data=5'h1F → no change anywhere.
  - Assert clr while swap is pending → pending cleared; no swap_ack after release; all buffers 0.

Source files
------------

// File: rtl/modulo_matriz_pkg.sv
// rtl/modulo_matriz_pkg.sv - shared geometry constants and index helpers for the matrix buffer
package modulo_matriz_pkg;

   localparam int DEF_ROWS = 7;
   localparam int DEF_COLS = 5;

   // Never returns 0, so single-value counters still get a 1-bit register
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_ROW_W = idx_w(DEF_ROWS);

   function automatic int idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

endpackage

// File: rtl/modulo_varredura_linhas.sv
// rtl/modulo_varredura_linhas.sv - row scanner: clock divider, row counter, one-hot drive and frame markers
module modulo_varredura_linhas
   import modulo_matriz_pkg::*;
#(
   parameter int ROWS     = DEF_ROWS,
   parameter int SCAN_DIV = 1000,
   localparam int ROW_W   = idx_w(ROWS),
   localparam int DIV_W   = idx_w(SCAN_DIV)
) (
   input  logic             clk,
   input  logic             clr,
   output logic [ROW_W-1:0] row,
   output logic [ROW_W-1:0] row_next,
   output logic             step,
   output logic [ROWS-1:0]  row_sel,
   output logic             boundary,
   output logic             frame_start
);

   logic [DIV_W-1:0] div;

   always_comb begin
      step     = (div == DIV_W'(SCAN_DIV - 1));
      boundary = step && (row == ROW_W'(ROWS - 1));
      row_next = row;
      if (step)
         row_next = (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         div         <= '0;
         row         <= '0;
         row_sel     <= ROWS'(1);
         frame_start <= 1'b0;
      end else begin
         div         <= step ? '0 : div + 1'b1;
         row         <= row_next;
         frame_start <= boundary;
         if (step)
            row_sel <= ROWS'(1) << row_next;
      end
   end

endmodule

// File: rtl/modulo_matriz_buffer.sv
// rtl/modulo_matriz_buffer.sv - double-buffered LED matrix frame register with tear-free swap and row scan
module modulo_matriz_buffer
   import modulo_matriz_pkg::*;
#(
   parameter int ROWS     = DEF_ROWS,
   parameter int COLS     = DEF_COLS,
   parameter int SCAN_DIV = 1000,
   localparam int ROW_W   = idx_w(ROWS)
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 wr_en,
   input  logic [ROW_W-1:0]     wr_row,
   input  logic [COLS-1:0]      wr_data,
   input  logic                 swap_req,
   output logic                 swap_ack,
   output logic [ROWS*COLS-1:0] frame_out,
   output logic [ROWS-1:0]      row_sel,
   output logic [COLS-1:0]      col_out,
   output logic                 frame_start
);

   logic [COLS-1:0]  back   [ROWS];
   logic [COLS-1:0]  active [ROWS];
   logic             pending;
   logic             do_swap;
   logic             step;
   logic             boundary;
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] row_next;

   modulo_varredura_linhas #(
      .ROWS     (ROWS),
      .SCAN_DIV (SCAN_DIV)
   ) u_varredura (
      .clk         (clk),
      .clr         (clr),
      .row         (row),
      .row_next    (row_next),
      .step        (step),
      .row_sel     (row_sel),
      .boundary    (boundary),
      .frame_start (frame_start)
   );

   assign do_swap = boundary && (pending || swap_req);

   // Nonblocking copy means a write on the swap edge lands only in back
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int r = 0; r < ROWS; r++) begin
            back[r]   <= '0;
            active[r] <= '0;
         end
         pending  <= 1'b0;
         swap_ack <= 1'b0;
         col_out  <= '0;
      end else begin
         if (wr_en && (int'(wr_row) < ROWS))
            back[wr_row] <= wr_data;
         if (do_swap)
            for (int r = 0; r < ROWS; r++)
               active[r] <= back[r];
         pending  <= do_swap ? 1'b0 : (pending | swap_req);
         swap_ack <= do_swap;
         if (step)
            col_out <= do_swap ? back[row_next] : active[row_next];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         assign frame_out[idx(r, c, COLS)] = active[r][c];
      end
   end

   logic unused_row;
   assign unused_row = ^row;

endmodule

// File: tb/tb_modulo_matriz_buffer.sv
// tb/tb_modulo_matriz_buffer.sv - scoreboard bench with a frame-level reference model for the matrix buffer
module tb_modulo_matriz_buffer;

   localparam int ROWS  = 7;
   localparam int COLS  = 5;
   localparam int SD    = 4;
   localparam int FRAME = ROWS * SD;

   logic                 clk = 1'b0;
   logic                 clr = 1'b0;
   logic                 wr_en = 1'b0;
   logic [2:0]           wr_row = '0;
   logic [COLS-1:0]      wr_data = '0;
   logic                 swap_req = 1'b0;
   logic                 swap_ack;
   logic [ROWS*COLS-1:0] frame_out;
   logic [ROWS-1:0]      row_sel;
   logic [COLS-1:0]      col_out;
   logic                 frame_start;

   modulo_matriz_buffer #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD)) dut (
      .clk         (clk),
      .clr         (clr),
      .wr_en       (wr_en),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .frame_out   (frame_out),
      .row_sel     (row_sel),
      .col_out     (col_out),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: t counts clock edges since reset release
   int              t = 0;
   logic [COLS-1:0] back_m [ROWS];
   logic [COLS-1:0] act_m  [ROWS];
   bit              pend_m = 1'b0;

   typedef struct {
      int                   cyc;
      logic [ROWS*COLS-1:0] frame;
   } exp_t;
   exp_t q[$];

   function automatic logic [ROWS*COLS-1:0] flat_act();
      logic [ROWS*COLS-1:0] f;
      for (int r = 0; r < ROWS; r++)
         f[r*COLS +: COLS] = act_m[r];
      return f;
   endfunction

   task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, actual, expected);
      end
   endtask

   initial begin
      for (int r = 0; r < ROWS; r++) begin
         back_m[r] = '0;
         act_m[r]  = '0;
      end
   end

   always @(posedge clk) begin
      if (!clr) begin
         t = 0;
         pend_m = 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            back_m[r] = '0;
            act_m[r]  = '0;
         end
         q.delete();
      end else begin
         if ((t % FRAME == FRAME - 1) && (pend_m || swap_req)) begin
            for (int r = 0; r < ROWS; r++)
               act_m[r] = back_m[r];
            q.push_back('{t + 1, flat_act()});
            pend_m = 1'b0;
         end else begin
            pend_m = pend_m | swap_req;
         end
         if (wr_en && int'(wr_row) < ROWS)
            back_m[wr_row] = wr_data;
         t++;
      end
   end

   always @(posedge clk) begin
      int   row;
      exp_t e;
      #1;
      row = (t / SD) % ROWS;
      chk("row_sel", 64'(row_sel), 64'(1) << row);
      chk("col_out", 64'(col_out), 64'(act_m[row]));
      chk("frame_out", 64'(frame_out), 64'(flat_act()));
      chk("frame_start", 64'(frame_start), 64'(t > 0 && t % FRAME == 0));
      if (swap_ack) begin
         if (q.size() == 0) begin
            chk("swap_ack_spurious", 64'(1), 64'(0));
         end else begin
            e = q.pop_front();
            chk("swap_ack_cycle", 64'(t), 64'(e.cyc));
            chk("swap_frame", 64'(frame_out), 64'(e.frame));
         end
      end else if (q.size() > 0 && q[0].cyc <= t) begin
         chk("swap_ack_missing", 64'(0), 64'(1));
         void'(q.pop_front());
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_phase(input int ph);
      for (int i = 0; i < FRAME + 1 && (t % FRAME) != ph; i++)
         tick();
   endtask

   task automatic wr(input int r, input int d);
      wr_en = 1'b1;
      wr_row = 3'(r);
      wr_data = COLS'(d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_swap();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
   endtask

   initial begin
      tick(3);
      clr = 1'b1;
      tick(2);
      wr(2, 5'b10101);
      tick(3 * FRAME);

      for (int r = 0; r < ROWS; r++)
         wr(r, r + 1);
      wait_phase(3 * SD + 1);
      pulse_swap();
      tick(2 * FRAME);

      wait_phase(2);
      pulse_swap();
      tick(5);
      pulse_swap();
      tick(5);
      pulse_swap();
      tick(FRAME);
      wait_phase(0);
      pulse_swap();
      tick(FRAME + 2);

      wait_phase(FRAME - 1);
      swap_req = 1'b1;
      wr(0, 5'h1F);
      swap_req = 1'b0;
      tick(FRAME);
      pulse_swap();
      tick(FRAME + 2);

      wr(7, 5'h1F);
      tick(2);
      wr(4, 5'h0A);
      pulse_swap();
      tick(3);
      clr = 1'b0;
      tick(2);
      clr = 1'b1;
      tick(2 * FRAME);

      for (int i = 0; i < 2000; i++) begin
         wr_en    = ($urandom_range(0, 2) == 0);
         wr_row   = 3'($urandom_range(0, 7));
         wr_data  = COLS'($urandom);
         swap_req = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 600) == 0)
            clr = 1'b0;
         else
            clr = 1'b1;
         tick();
      end
      wr_en = 1'b0;
      swap_req = 1'b0;
      clr = 1'b1;
      tick(FRAME + 2);

      chk("scoreboard_drained", 64'(q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
